pipe_stage_regs: RTL and testbench
==================================

Name: pipe_stage_regs

Overview:
- Holds the four RV32I pipeline boundary registers (IF/ID, ID/EX, EX/MEM, MEM/WB) and applies per-stage stall/flush commands from the hazard logic.
- Returns the EX/MEM/WB instruction words and MEM/WB register-write enables that the hazard logic consumes, closing the forwarding/stall loop.
- Also keeps retire, stall and flush event counters for bring-up.

Parameters:
- XLEN, 32, datapath and PC width.
- CTRL_W, 8, width of the opaque decoded-control bundle carried ID→WB; bit 0 is RegWEn.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- CNT_W, 32, event counter width.

Ports:
- clk_i  in  1  core clock
- rst_ni  in  1  asynchronous active-low reset
- pc_if_i  in  XLEN  fetch PC
- inst_if_i  in  32  fetched instruction
- ctrl_id_i  in  CTRL_W  decoded control from ID
- data_id_i  in  2*XLEN  {rs1,rs2} operands from ID
- data_ex_i  in  2*XLEN  {alu_result,store_data} from EX
- data_mem_i  in  XLEN  writeback value from MEM
- Stall_IF/ID/EX/MEM/WB  in  1 each  hold commands
- Flush_ID/EX/MEM/WB  in  1 each  bubble commands
- pc_id_o, pc_ex_o  out  XLEN  stage PCs
- inst_id_o, inst_ex_o, inst_mem_o, inst_wb_o  out  32  stage instructions
- ctrl_ex_o, ctrl_mem_o, ctrl_wb_o  out  CTRL_W  stage control
- RegWEn_mem_o, RegWEn_wb_o  out  1  ctrl_mem_o[0], ctrl_wb_o[0]
- data_ex_o  out  2*XLEN  ; data_mem_o  out  2*XLEN  ; data_wb_o  out  XLEN
- valid_id_o … valid_wb_o  out  1 each  stage holds a real instruction
- pc_en_o  out  1  ~Stall_IF; gates PC register
- retire_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_W  event counters

Behaviour:
- Reset: every stage is a bubble: inst = NOP_INST, pc = 0, ctrl = 0, data = 0, valid = 0. All counters = 0. pc_en_o = 1 combinationally once reset deasserts.
- Per rising edge, each boundary register X is updated by priority:
  1. Flush_X: load bubble, even if Stall_X is also asserted (flush wins; covers load-use coincident with taken branch).
  2. Stall_X: hold all fields.
  3. Otherwise: capture the upstream stage's fields.
- Boundary mapping:
  - IF/ID is controlled by Stall_ID/Flush_ID; it captures pc_if_i and inst_if_i, and valid = 1.
  - ID/EX uses Stall_EX/Flush_EX and captures the IF/ID fields, ctrl_id_i and data_id_i.
  - EX/MEM uses Stall_MEM/Flush_MEM; MEM/WB uses Stall_WB/Flush_WB.
  - valid propagates with its instruction.
- Bubble insertion: when a stage holds (Stall_EX=1) and the next stage is neither stalled nor flushed, the hazard unit asserts Flush_MEM. This block does not synthesize bubbles itself. A non-flushed, non-stalled downstream register captures the held upstream contents as-is.
- Latency: one cycle per boundary; IF→WB is 4 edges with no hazards.
- RegWEn_*_o, inst_*_o and valid outputs are pure register outputs with no combinational path from stall/flush inputs. This avoids a loop with the hazard unit.
- Counters, 32-bit wrap-around with no saturation:
  - retire_cnt increments each cycle valid_wb_o = 1 and Stall_WB = 0.
  - stall_cnt increments each cycle Stall_IF = 1.
  - flush_cnt increments each cycle Flush_ID = 1.
- Reset asserted mid-operation clears all state asynchronously. In-flight instructions are discarded and not counted.
- Illegal combination (Stall_X=1 while an upstream stage is not stalled) is not checked. Upstream data is simply lost, as a hazard-unit error.

Decomposition:
- Shared package (core_pkg):
  - NOP_INST.
  - Typedef stage_t {pc, inst, ctrl, valid}.
  - Field indices for ctrl (CTRL_REGWEN = 0).
- One natural sub-module, pipe_reg: parameterised width, with clk_i, rst_ni, stall, flush, reset/bubble value, d, q. It is instantiated once per boundary; counters stay in the top.

Test Plan:
- Reset then stream addi x1..x4: after 4 edges inst_wb_o = first addi, retire_cnt_o increments by 1 per cycle thereafter, and valid_* all 1.
- Stall_IF/ID/EX = 1 plus Flush_MEM = 1 for one cycle after lw x5 in EX/MEM with add x6,x5,x5 in EX:
  - inst_ex_o holds add, inst_mem_o = 0x00000013 with valid_mem_o = 0, pc_en_o = 0.
  - stall_cnt_o increments by 1.
- Flush_ID = Flush_EX = 1 for one cycle (taken branch): inst_id_o and inst_ex_o = NOP_INST, RegWEn of the flushed stages = 0, flush_cnt_o increments by 1.
- Stall_EX = 1 and Flush_EX = 1 in the same cycle: ID/EX becomes a bubble (flush priority).
- rst_ni pulled low asynchronously mid-stream, between clock edges: all outputs return to reset values immediately, and counters read 0.
- Force retire_cnt to 32'hFFFF_FFFF and retire one instruction → counter reads 0.

Source files
------------

// File: rtl/pipe_stage_regs_pkg.sv
// pipe_stage_regs_pkg
//   Shared widths, bubble encoding and boundary-register record types for the
//   RV32I pipeline boundary registers.
//   Records:
//     ifid_t   - IF/ID  : pc, inst, valid
//     stage_t  - generic stage view : pc, inst, ctrl, valid
//     idex_t   - ID/EX  : stage_t + {rs1,rs2}
//     exmem_t  - EX/MEM : inst, ctrl, valid + {alu_result,store_data}
//     memwb_t  - MEM/WB : inst, ctrl, valid + writeback value
package pipe_stage_regs_pkg;

  localparam int XLEN        = 32;
  localparam int CTRL_W      = 8;
  localparam int CTRL_REGWEN = 0;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic              valid;
  } ifid_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [31:0]       inst;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
  } stage_t;

  typedef struct packed {
    stage_t            st;
    logic [2*XLEN-1:0] data;
  } idex_t;

  // PCs are not needed past EX, so the later boundaries drop them.
  typedef struct packed {
    logic [31:0]       inst;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic [2*XLEN-1:0] data;
  } exmem_t;

  typedef struct packed {
    logic [31:0]       inst;
    logic [CTRL_W-1:0] ctrl;
    logic              valid;
    logic [XLEN-1:0]   data;
  } memwb_t;

  localparam ifid_t  IFID_BUBBLE  = '{pc: '0, inst: NOP_INST, valid: 1'b0};
  localparam stage_t STAGE_BUBBLE = '{pc: '0, inst: NOP_INST, ctrl: '0, valid: 1'b0};
  localparam idex_t  IDEX_BUBBLE  = '{st: STAGE_BUBBLE, data: '0};
  localparam exmem_t EXMEM_BUBBLE = '{inst: NOP_INST, ctrl: '0, valid: 1'b0, data: '0};
  localparam memwb_t MEMWB_BUBBLE = '{inst: NOP_INST, ctrl: '0, valid: 1'b0, data: '0};

endpackage

// File: rtl/pipe_stage_regs_if.sv
// pipe_stage_regs_if
//   Bundle between the datapath/hazard unit and the pipeline boundary
//   registers.
//   master : datapath + hazard unit (drives stage inputs and stall/flush)
//   slave  : pipe_stage_regs (returns stage contents, pc_en, counters)
interface pipe_stage_regs_if #(
  parameter int CNT_W = 32
);
  import pipe_stage_regs_pkg::*;

  logic [XLEN-1:0]   pc_if_i;
  logic [31:0]       inst_if_i;
  logic [CTRL_W-1:0] ctrl_id_i;
  logic [2*XLEN-1:0] data_id_i;
  logic [2*XLEN-1:0] data_ex_i;
  logic [XLEN-1:0]   data_mem_i;

  logic Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Stall_WB;
  logic Flush_ID, Flush_EX, Flush_MEM, Flush_WB;

  logic [XLEN-1:0]   pc_id_o, pc_ex_o;
  logic [31:0]       inst_id_o, inst_ex_o, inst_mem_o, inst_wb_o;
  logic [CTRL_W-1:0] ctrl_ex_o, ctrl_mem_o, ctrl_wb_o;
  logic              RegWEn_mem_o, RegWEn_wb_o;
  logic [2*XLEN-1:0] data_ex_o, data_mem_o;
  logic [XLEN-1:0]   data_wb_o;
  logic              valid_id_o, valid_ex_o, valid_mem_o, valid_wb_o;
  logic              pc_en_o;
  logic [CNT_W-1:0]  retire_cnt_o, stall_cnt_o, flush_cnt_o;

  modport master (
    output pc_if_i, inst_if_i, ctrl_id_i, data_id_i, data_ex_i, data_mem_i,
    output Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Stall_WB,
    output Flush_ID, Flush_EX, Flush_MEM, Flush_WB,
    input  pc_id_o, pc_ex_o, inst_id_o, inst_ex_o, inst_mem_o, inst_wb_o,
    input  ctrl_ex_o, ctrl_mem_o, ctrl_wb_o, RegWEn_mem_o, RegWEn_wb_o,
    input  data_ex_o, data_mem_o, data_wb_o,
    input  valid_id_o, valid_ex_o, valid_mem_o, valid_wb_o,
    input  pc_en_o, retire_cnt_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pc_if_i, inst_if_i, ctrl_id_i, data_id_i, data_ex_i, data_mem_i,
    input  Stall_IF, Stall_ID, Stall_EX, Stall_MEM, Stall_WB,
    input  Flush_ID, Flush_EX, Flush_MEM, Flush_WB,
    output pc_id_o, pc_ex_o, inst_id_o, inst_ex_o, inst_mem_o, inst_wb_o,
    output ctrl_ex_o, ctrl_mem_o, ctrl_wb_o, RegWEn_mem_o, RegWEn_wb_o,
    output data_ex_o, data_mem_o, data_wb_o,
    output valid_id_o, valid_ex_o, valid_mem_o, valid_wb_o,
    output pc_en_o, retire_cnt_o, stall_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/pipe_stage_regs_pipe_reg.sv
// pipe_reg
//   One pipeline boundary register with flush > stall > capture priority.
//   Ports:
//     clk_i, rst_ni   clock, async active-low reset (loads BUBBLE)
//     stall_i         hold current contents
//     flush_i         load BUBBLE (wins over stall_i)
//     d_i             upstream stage contents
//     q_o             registered contents
module pipe_reg #(
  parameter int           W      = 1,
  parameter logic [W-1:0] BUBBLE = '0
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] q_q, q_d;

  // A flush coinciding with a stall (load-use stall plus taken branch) must
  // still squash the stage, so flush is checked first.
  always_comb begin
    q_d = q_q;
    if (flush_i) begin
      q_d = BUBBLE;
    end else if (!stall_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/pipe_stage_regs.sv
// pipe_stage_regs
//   IF/ID, ID/EX, EX/MEM and MEM/WB boundary registers plus bring-up event
//   counters. Stall/flush commands come from the hazard unit; every stage
//   output is a plain register output so the hazard unit can consume them
//   without forming a combinational loop.
//   Ports:
//     clk_i, rst_ni   core clock, async active-low reset
//     bus (slave)     stage inputs, stall/flush commands, stage outputs,
//                     pc_en_o and retire/stall/flush counters
module pipe_stage_regs
  import pipe_stage_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  pipe_stage_regs_if.slave  bus
);

  ifid_t  if_id_d,  if_id_q;
  idex_t  id_ex_d,  id_ex_q;
  exmem_t ex_mem_d, ex_mem_q;
  memwb_t mem_wb_d, mem_wb_q;

  logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q,  stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q,  flush_cnt_d;

  // Anything fetched is a real instruction; bubbles only come from flushes.
  assign if_id_d = '{pc: bus.pc_if_i, inst: bus.inst_if_i, valid: 1'b1};

  assign id_ex_d = '{
    st:   '{pc: if_id_q.pc, inst: if_id_q.inst, ctrl: bus.ctrl_id_i, valid: if_id_q.valid},
    data: bus.data_id_i
  };

  assign ex_mem_d = '{
    inst:  id_ex_q.st.inst,
    ctrl:  id_ex_q.st.ctrl,
    valid: id_ex_q.st.valid,
    data:  bus.data_ex_i
  };

  assign mem_wb_d = '{
    inst:  ex_mem_q.inst,
    ctrl:  ex_mem_q.ctrl,
    valid: ex_mem_q.valid,
    data:  bus.data_mem_i
  };

  pipe_reg #(.W($bits(ifid_t)), .BUBBLE(IFID_BUBBLE)) u_if_id (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (bus.Stall_ID),
    .flush_i (bus.Flush_ID),
    .d_i     (if_id_d),
    .q_o     (if_id_q)
  );

  pipe_reg #(.W($bits(idex_t)), .BUBBLE(IDEX_BUBBLE)) u_id_ex (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (bus.Stall_EX),
    .flush_i (bus.Flush_EX),
    .d_i     (id_ex_d),
    .q_o     (id_ex_q)
  );

  pipe_reg #(.W($bits(exmem_t)), .BUBBLE(EXMEM_BUBBLE)) u_ex_mem (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (bus.Stall_MEM),
    .flush_i (bus.Flush_MEM),
    .d_i     (ex_mem_d),
    .q_o     (ex_mem_q)
  );

  pipe_reg #(.W($bits(memwb_t)), .BUBBLE(MEMWB_BUBBLE)) u_mem_wb (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .stall_i (bus.Stall_WB),
    .flush_i (bus.Flush_WB),
    .d_i     (mem_wb_d),
    .q_o     (mem_wb_q)
  );

  // Counters wrap freely; a held WB stage is not a retirement.
  always_comb begin
    retire_cnt_d = retire_cnt_q;
    stall_cnt_d  = stall_cnt_q;
    flush_cnt_d  = flush_cnt_q;
    if (mem_wb_q.valid && !bus.Stall_WB) retire_cnt_d = retire_cnt_q + 1'b1;
    if (bus.Stall_IF)                    stall_cnt_d  = stall_cnt_q + 1'b1;
    if (bus.Flush_ID)                    flush_cnt_d  = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      retire_cnt_q <= '0;
      stall_cnt_q  <= '0;
      flush_cnt_q  <= '0;
    end else begin
      retire_cnt_q <= retire_cnt_d;
      stall_cnt_q  <= stall_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign bus.pc_id_o      = if_id_q.pc;
  assign bus.pc_ex_o      = id_ex_q.st.pc;
  assign bus.inst_id_o    = if_id_q.inst;
  assign bus.inst_ex_o    = id_ex_q.st.inst;
  assign bus.inst_mem_o   = ex_mem_q.inst;
  assign bus.inst_wb_o    = mem_wb_q.inst;
  assign bus.ctrl_ex_o    = id_ex_q.st.ctrl;
  assign bus.ctrl_mem_o   = ex_mem_q.ctrl;
  assign bus.ctrl_wb_o    = mem_wb_q.ctrl;
  assign bus.RegWEn_mem_o = ex_mem_q.ctrl[CTRL_REGWEN];
  assign bus.RegWEn_wb_o  = mem_wb_q.ctrl[CTRL_REGWEN];
  assign bus.data_ex_o    = id_ex_q.data;
  assign bus.data_mem_o   = ex_mem_q.data;
  assign bus.data_wb_o    = mem_wb_q.data;
  assign bus.valid_id_o   = if_id_q.valid;
  assign bus.valid_ex_o   = id_ex_q.st.valid;
  assign bus.valid_mem_o  = ex_mem_q.valid;
  assign bus.valid_wb_o   = mem_wb_q.valid;
  // The only combinational output; it gates the PC register, not the hazard unit.
  assign bus.pc_en_o      = ~bus.Stall_IF;
  assign bus.retire_cnt_o = retire_cnt_q;
  assign bus.stall_cnt_o  = stall_cnt_q;
  assign bus.flush_cnt_o  = flush_cnt_q;

endmodule

// File: tb/tb_pipe_stage_regs.sv
module tb_pipe_stage_regs;
  import pipe_stage_regs_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pipe_stage_regs_if #(.CNT_W(32)) bus ();
  pipe_stage_regs_if #(.CNT_W(3))  bus_s ();

  pipe_stage_regs #(.CNT_W(32)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
  pipe_stage_regs #(.CNT_W(3))  dut_s (.clk_i(clk), .rst_ni(rst_n), .bus(bus_s));

  // Narrow-counter copy sees identical stimulus, used to observe wrap-around.
  assign bus_s.pc_if_i    = bus.pc_if_i;
  assign bus_s.inst_if_i  = bus.inst_if_i;
  assign bus_s.ctrl_id_i  = bus.ctrl_id_i;
  assign bus_s.data_id_i  = bus.data_id_i;
  assign bus_s.data_ex_i  = bus.data_ex_i;
  assign bus_s.data_mem_i = bus.data_mem_i;
  assign bus_s.Stall_IF   = bus.Stall_IF;
  assign bus_s.Stall_ID   = bus.Stall_ID;
  assign bus_s.Stall_EX   = bus.Stall_EX;
  assign bus_s.Stall_MEM  = bus.Stall_MEM;
  assign bus_s.Stall_WB   = bus.Stall_WB;
  assign bus_s.Flush_ID   = bus.Flush_ID;
  assign bus_s.Flush_EX   = bus.Flush_EX;
  assign bus_s.Flush_MEM  = bus.Flush_MEM;
  assign bus_s.Flush_WB   = bus.Flush_WB;

  int n_checks = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: stage index 0=ID 1=EX 2=MEM 3=WB
  logic [31:0] m_pc [4];
  logic [31:0] m_inst [4];
  logic [7:0]  m_ctrl [4];
  logic        m_valid [4];
  logic [63:0] m_data [4];
  int unsigned m_retire, m_stall, m_flush;

  task automatic mreset();
    for (int s = 0; s < 4; s++) begin
      m_pc[s] = '0; m_inst[s] = 32'h0000_0013; m_ctrl[s] = '0;
      m_valid[s] = 1'b0; m_data[s] = '0;
    end
    m_retire = 0; m_stall = 0; m_flush = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mreset();
    end else begin
      logic st [4];
      logic fl [4];
      logic [31:0] u_pc, u_inst;
      logic [7:0]  u_ctrl;
      logic        u_valid;
      logic [63:0] u_data;
      st[0] = bus.Stall_ID; st[1] = bus.Stall_EX; st[2] = bus.Stall_MEM; st[3] = bus.Stall_WB;
      fl[0] = bus.Flush_ID; fl[1] = bus.Flush_EX; fl[2] = bus.Flush_MEM; fl[3] = bus.Flush_WB;
      if (m_valid[3] && !bus.Stall_WB) m_retire++;
      if (bus.Stall_IF) m_stall++;
      if (bus.Flush_ID) m_flush++;
      for (int s = 3; s >= 0; s--) begin
        if (s == 0) begin
          u_pc = bus.pc_if_i; u_inst = bus.inst_if_i; u_ctrl = '0; u_valid = 1'b1; u_data = '0;
        end else begin
          u_pc = m_pc[s-1]; u_inst = m_inst[s-1]; u_valid = m_valid[s-1];
          u_ctrl = (s == 1) ? bus.ctrl_id_i : m_ctrl[s-1];
          u_data = (s == 1) ? bus.data_id_i : (s == 2) ? bus.data_ex_i : {32'h0, bus.data_mem_i};
        end
        if (fl[s]) begin
          m_pc[s] = '0; m_inst[s] = 32'h0000_0013; m_ctrl[s] = '0; m_valid[s] = 1'b0; m_data[s] = '0;
        end else if (!st[s]) begin
          m_pc[s] = u_pc; m_inst[s] = u_inst; m_ctrl[s] = u_ctrl; m_valid[s] = u_valid; m_data[s] = u_data;
        end
      end
    end
  end

  // ---------------- per-cycle compare, away from the active edge
  always @(negedge clk) begin
    chk("pc_id",      bus.pc_id_o,      m_pc[0]);
    chk("pc_ex",      bus.pc_ex_o,      m_pc[1]);
    chk("inst_id",    bus.inst_id_o,    m_inst[0]);
    chk("inst_ex",    bus.inst_ex_o,    m_inst[1]);
    chk("inst_mem",   bus.inst_mem_o,   m_inst[2]);
    chk("inst_wb",    bus.inst_wb_o,    m_inst[3]);
    chk("ctrl_ex",    bus.ctrl_ex_o,    m_ctrl[1]);
    chk("ctrl_mem",   bus.ctrl_mem_o,   m_ctrl[2]);
    chk("ctrl_wb",    bus.ctrl_wb_o,    m_ctrl[3]);
    chk("regwen_mem", bus.RegWEn_mem_o, m_ctrl[2][0]);
    chk("regwen_wb",  bus.RegWEn_wb_o,  m_ctrl[3][0]);
    chk("data_ex",    bus.data_ex_o,    m_data[1]);
    chk("data_mem",   bus.data_mem_o,   m_data[2]);
    chk("data_wb",    bus.data_wb_o,    m_data[3]);
    chk("valid_id",   bus.valid_id_o,   m_valid[0]);
    chk("valid_ex",   bus.valid_ex_o,   m_valid[1]);
    chk("valid_mem",  bus.valid_mem_o,  m_valid[2]);
    chk("valid_wb",   bus.valid_wb_o,   m_valid[3]);
    chk("pc_en",      bus.pc_en_o,      !bus.Stall_IF);
    chk("retire_cnt", bus.retire_cnt_o, m_retire);
    chk("stall_cnt",  bus.stall_cnt_o,  m_stall);
    chk("flush_cnt",  bus.flush_cnt_o,  m_flush);
    chk("retire_cnt_w3", bus_s.retire_cnt_o, m_retire % 8);
  end

  // ---------------- stimulus
  int idx = 0;
  int cyc = 0;

  function automatic logic [31:0] prog(input int i);
    logic [31:0] v;
    case (i)
      0: v = 32'h0010_0093;  // addi x1,x0,1
      1: v = 32'h0020_0113;  // addi x2,x0,2
      2: v = 32'h0030_0193;  // addi x3,x0,3
      3: v = 32'h0040_0213;  // addi x4,x0,4
      4: v = 32'h0000_A283;  // lw   x5,0(x1)
      5: v = 32'h0052_8333;  // add  x6,x5,x5
      6: v = 32'h0000_0463;  // beq  x0,x0,8
      default: v = 32'h0000_0013 | (32'(i & 31) << 7) | (32'(i & 12'hfff) << 20);
    endcase
    return v;
  endfunction

  // st = {IF,ID,EX,MEM,WB}, fl = {ID,EX,MEM,WB}
  task automatic drive(input logic [4:0] st, input logic [3:0] fl);
    bus.Stall_IF  = st[4]; bus.Stall_ID = st[3]; bus.Stall_EX = st[2];
    bus.Stall_MEM = st[1]; bus.Stall_WB = st[0];
    bus.Flush_ID  = fl[3]; bus.Flush_EX = fl[2]; bus.Flush_MEM = fl[1]; bus.Flush_WB = fl[0];
    bus.pc_if_i    = 32'(idx * 4);
    bus.inst_if_i  = prog(idx);
    bus.ctrl_id_i  = 8'(cyc * 37 + 1);
    bus.data_id_i  = {32'(cyc * 3), 32'(cyc * 5 + 1)};
    bus.data_ex_i  = {32'(cyc * 11), ~32'(cyc)};
    bus.data_mem_i = 32'(cyc * 13 + 7);
  endtask

  task automatic tick();
    @(posedge clk);
    if (!bus.Stall_IF) idx++;
    cyc++;
    #1;
  endtask

  task automatic run_norm(input int n);
    for (int k = 0; k < n; k++) begin
      drive(5'b0, 4'b0);
      tick();
    end
  endtask

  initial begin
    drive(5'b0, 4'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_inst_wb",   bus.inst_wb_o, 32'h0000_0013);
    chk("rst_valid_id",  bus.valid_id_o, 1'b0);
    chk("rst_retire",    bus.retire_cnt_o, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("rst_pc_en", bus.pc_en_o, 1'b1);

    // stream: edges 1..7 with no hazards
    run_norm(4);
    chk("stream_inst_wb", bus.inst_wb_o, 32'h0010_0093);
    chk("stream_valid_all", {bus.valid_id_o, bus.valid_ex_o, bus.valid_mem_o, bus.valid_wb_o}, 4'b1111);
    chk("stream_retire0", bus.retire_cnt_o, 32'd0);
    run_norm(1);
    chk("stream_retire1", bus.retire_cnt_o, 32'd1);
    run_norm(1);
    chk("stream_retire2", bus.retire_cnt_o, 32'd2);
    run_norm(1);
    chk("lu_pre_ex",  bus.inst_ex_o,  32'h0052_8333);
    chk("lu_pre_mem", bus.inst_mem_o, 32'h0000_A283);

    // load-use: hold IF/ID/EX, bubble into EX/MEM
    drive(5'b11100, 4'b0010);
    #1;
    chk("lu_pc_en", bus.pc_en_o, 1'b0);
    tick();
    chk("lu_ex_hold",  bus.inst_ex_o,   32'h0052_8333);
    chk("lu_mem_nop",  bus.inst_mem_o,  32'h0000_0013);
    chk("lu_mem_vld",  bus.valid_mem_o, 1'b0);
    chk("lu_wb_lw",    bus.inst_wb_o,   32'h0000_A283);
    chk("lu_stall",    bus.stall_cnt_o, 32'd1);

    // taken branch: flush ID and EX
    run_norm(1);
    drive(5'b0, 4'b1100);
    tick();
    chk("br_id_nop",   bus.inst_id_o,    32'h0000_0013);
    chk("br_ex_nop",   bus.inst_ex_o,    32'h0000_0013);
    chk("br_ex_regwen", bus.ctrl_ex_o[0], 1'b0);
    chk("br_id_vld",   bus.valid_id_o,   1'b0);
    chk("br_flush",    bus.flush_cnt_o,  32'd1);
    chk("br_wb_add",   bus.inst_wb_o,    32'h0052_8333);

    // stall and flush together on ID/EX: flush wins
    run_norm(2);
    drive(5'b11100, 4'b0100);
    tick();
    chk("sf_ex_nop",  bus.inst_ex_o,  32'h0000_0013);
    chk("sf_ex_vld",  bus.valid_ex_o, 1'b0);
    chk("sf_id_hold", bus.inst_id_o,  prog(10));
    chk("sf_stall",   bus.stall_cnt_o, 32'd2);

    // run until 8 retirements: 3-bit counter must have wrapped to 0
    for (int k = 0; k < 60 && m_retire != 8; k++) run_norm(1);
    chk("wrap_reached", bus.retire_cnt_o, 32'd8);
    chk("wrap_w3_zero", bus_s.retire_cnt_o, 3'd0);
    run_norm(3);

    // asynchronous reset between clock edges
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_inst_id",  bus.inst_id_o,  32'h0000_0013);
    chk("arst_inst_ex",  bus.inst_ex_o,  32'h0000_0013);
    chk("arst_inst_mem", bus.inst_mem_o, 32'h0000_0013);
    chk("arst_inst_wb",  bus.inst_wb_o,  32'h0000_0013);
    chk("arst_valid", {bus.valid_id_o, bus.valid_ex_o, bus.valid_mem_o, bus.valid_wb_o}, 4'b0000);
    chk("arst_pc_ex",    bus.pc_ex_o,    32'd0);
    chk("arst_ctrl_wb",  bus.ctrl_wb_o,  8'd0);
    chk("arst_data_mem", bus.data_mem_o, 64'd0);
    chk("arst_retire",   bus.retire_cnt_o, 32'd0);
    chk("arst_stall",    bus.stall_cnt_o,  32'd0);
    chk("arst_flush",    bus.flush_cnt_o,  32'd0);
    chk("arst_regwen",   {bus.RegWEn_mem_o, bus.RegWEn_wb_o}, 2'b00);
    #2 rst_n = 1'b1;
    idx = 0;
    run_norm(4);
    chk("post_rst_wb", bus.inst_wb_o, 32'h0010_0093);
    run_norm(2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
